fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 15 +
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader_stream_buf3.sv | 43 ++++
 rtl/fifo_stream_reader.sv | 47 ++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader and its 3-entry buffer.
package fifo_reader_pkg;

   localparam int unsigned BUF_DEPTH  = 3;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned CNT_WIDTH  = 16;

   typedef logic [1:0] ptr_t;

   // Circular pointer advance over BUF_DEPTH slots.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus output stream handshake, bundled for the reader.
interface fifo_stream_reader_if
   import fifo_reader_pkg::*;
#(
   parameter int unsigned data_width = DATA_WIDTH
);
   logic                  empty;
   logic                  r_en;
   logic [data_width-1:0] fifo_data;
   logic [data_width-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (
      input  empty, fifo_data, m_ready,
      output r_en, m_data, m_valid
   );

   modport slave (
      output empty, fifo_data, m_ready,
      input  r_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_stream_reader_stream_buf3.sv
// 3-entry in-order buffer with registered occupancy and head/tail pointers.
module stream_buf3
   import fifo_reader_pkg::*;
#(
   parameter int unsigned data_width = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [data_width-1:0] din,
   output logic [data_width-1:0] dout,
   output logic [1:0]            occ
);

   logic [data_width-1:0] mem [BUF_DEPTH];
   ptr_t                  head;
   ptr_t                  tail;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage is not reset; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= din;
   end

   assign dout = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Credit-based FIFO reader: keeps at most 3 words buffered or in flight, streams them out.
module fifo_stream_reader
   import fifo_reader_pkg::*;
#(
   parameter int unsigned data_width = DATA_WIDTH,
   parameter int unsigned cnt_width  = CNT_WIDTH
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   fifo_stream_reader_if.master bus,
   output logic [cnt_width-1:0] rd_count
);

   logic       infl;
   logic [1:0] occ;
   logic [2:0] credit_used;
   logic       pop;

   // r_en is gated by reset so it stays low while rrst_n is held.
   assign credit_used = {1'b0, occ} + {2'b00, infl};
   assign bus.r_en    = rrst_n && !bus.empty && (credit_used < 3'(BUF_DEPTH));
   assign bus.m_valid = (occ != '0);
   assign pop         = bus.m_valid && bus.m_ready;

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         infl     <= 1'b0;
         rd_count <= '0;
      end else begin
         infl <= bus.r_en;
         if (pop) rd_count <= rd_count + cnt_width'(1);
      end
   end

   stream_buf3 #(
      .data_width (data_width)
   ) u_buf (
      .clk   (rclk),
      .rst_n (rrst_n),
      .push  (infl),
      .pop   (pop),
      .din   (bus.fifo_data),
      .dout  (bus.m_data),
      .occ   (occ)
   );

endmodule
